usb_tx_line_encoder: RTL and testbench

USB full-speed transmit line stage that serializes packet bytes onto the D+/D- pair. It fetches bytes through a valid/ready handshake from the TX packet path, which sits upstream and is fed by the data buffer. It prepends SYNC, bit-stuffs, NRZI-encodes, and terminates each packet with EOP. This stage is the sole driver of dplus_out/dminus_out.

---
 rtl/usb_tx_line_encoder.sv | 200 ++++++++++++++++++++
 tb/tb_usb_tx_line_encoder.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/usb_tx_line_encoder.sv
// USB full-speed transmit line stage: SYNC, bit stuffing, NRZI and EOP onto D+/D-.
// Bytes are fetched LSB first through a valid/ready handshake at byte boundaries.
module usb_tx_line_encoder #(
    parameter int CLKS_PER_BIT = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    input  logic [7:0] tx_byte,
    input  logic       byte_valid,
    input  logic       byte_last,
    output logic       byte_ready,
    output logic       busy,
    output logic       done,
    output logic       error,
    output logic       dplus_out,
    output logic       dminus_out
);

    localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    typedef enum logic [2:0] {IDLE, SYNC, DATA, EOP_SE0, EOP_J} state_t;

    state_t        state_reg, state_next;
    logic [TW-1:0] timer_reg, timer_next;
    logic [7:0]    shift_reg, shift_next;
    logic [3:0]    bits_left_reg, bits_left_next;
    logic          last_reg, last_next;
    logic [2:0]    ones_reg, ones_next;
    logic          level_reg, level_next;
    logic          eop_cnt_reg, eop_cnt_next;
    logic          abort_pend_reg, abort_pend_next;
    logic          done_reg, done_next;
    logic          error_reg, error_next;
    logic          dplus_reg, dminus_reg;

    logic          boundary;
    logic          abort_eff;
    logic          ready_int;
    logic          go_eop;
    logic [7:0]    ld_shift;
    logic [3:0]    ld_left;
    logic          ld_last;
    logic          se0_next;

    assign boundary = (timer_reg == TW'(CLKS_PER_BIT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            timer_reg      <= '0;
            shift_reg      <= '0;
            bits_left_reg  <= '0;
            last_reg       <= 1'b0;
            ones_reg       <= '0;
            level_reg      <= 1'b1;
            eop_cnt_reg    <= 1'b0;
            abort_pend_reg <= 1'b0;
            done_reg       <= 1'b0;
            error_reg      <= 1'b0;
            dplus_reg      <= 1'b1;
            dminus_reg     <= 1'b0;
        end else begin
            state_reg      <= state_next;
            timer_reg      <= timer_next;
            shift_reg      <= shift_next;
            bits_left_reg  <= bits_left_next;
            last_reg       <= last_next;
            ones_reg       <= ones_next;
            level_reg      <= level_next;
            eop_cnt_reg    <= eop_cnt_next;
            abort_pend_reg <= abort_pend_next;
            done_reg       <= done_next;
            error_reg      <= error_next;
            dplus_reg      <= ~se0_next & level_next;
            dminus_reg     <= ~se0_next & ~level_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        timer_next      = timer_reg;
        shift_next      = shift_reg;
        bits_left_next  = bits_left_reg;
        last_next       = last_reg;
        ones_next       = ones_reg;
        level_next      = level_reg;
        eop_cnt_next    = eop_cnt_reg;
        abort_pend_next = abort_pend_reg;
        done_next       = 1'b0;
        error_next      = 1'b0;
        ready_int       = 1'b0;
        go_eop          = 1'b0;
        ld_shift        = shift_reg;
        ld_left         = bits_left_reg;
        ld_last         = last_reg;
        abort_eff       = abort_pend_reg | abort;

        if (state_reg != IDLE) begin
            timer_next = boundary ? '0 : timer_reg + TW'(1);
        end

        case (state_reg)
            IDLE: begin
                if (start) begin
                    // SYNC is shifted out like a byte; its first bit (0) goes out now as K.
                    state_next      = SYNC;
                    timer_next      = '0;
                    level_next      = 1'b0;
                    shift_next      = 8'h40;
                    bits_left_next  = 4'd7;
                    last_next       = 1'b0;
                    ones_next       = '0;
                    abort_pend_next = 1'b0;
                end
            end
            SYNC, DATA: begin
                if (abort) begin
                    abort_pend_next = 1'b1;
                end
                if (boundary) begin
                    if (abort_eff) begin
                        go_eop = 1'b1;
                    end else begin
                        if (bits_left_reg == 4'd0 && !last_reg) begin
                            // Ready is only raised when a byte is actually taken.
                            if (byte_valid) begin
                                ready_int  = 1'b1;
                                ld_shift   = tx_byte;
                                ld_left    = 4'd8;
                                ld_last    = byte_last;
                                state_next = DATA;
                            end else begin
                                error_next = 1'b1;
                                go_eop     = 1'b1;
                            end
                        end
                        if (!go_eop) begin
                            if (ones_reg == 3'd6) begin
                                level_next = ~level_reg;
                                ones_next  = '0;
                            end else if (ld_left == 4'd0) begin
                                go_eop = 1'b1;
                            end else begin
                                if (ld_shift[0]) begin
                                    ones_next = ones_reg + 3'd1;
                                end else begin
                                    ones_next  = '0;
                                    level_next = ~level_reg;
                                end
                                ld_shift = ld_shift >> 1;
                                ld_left  = ld_left - 4'd1;
                            end
                        end
                    end
                    shift_next     = ld_shift;
                    bits_left_next = ld_left;
                    last_next      = ld_last;
                    if (go_eop) begin
                        state_next      = EOP_SE0;
                        eop_cnt_next    = 1'b0;
                        abort_pend_next = 1'b0;
                    end
                end
            end
            EOP_SE0: begin
                if (boundary) begin
                    if (eop_cnt_reg) begin
                        state_next = EOP_J;
                        level_next = 1'b1;
                    end else begin
                        eop_cnt_next = 1'b1;
                    end
                end
            end
            EOP_J: begin
                if (boundary) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                    timer_next = '0;
                end
            end
            default: begin
                state_next = IDLE;
                level_next = 1'b1;
            end
        endcase

        se0_next = (state_next == EOP_SE0);
    end

    assign byte_ready = ready_int;
    assign busy       = (state_reg != IDLE);
    assign done       = done_reg;
    assign error      = error_reg;
    assign dplus_out  = dplus_reg;
    assign dminus_out = dminus_reg;

endmodule

// File: tb/tb_usb_tx_line_encoder.sv
// Directed bench for usb_tx_line_encoder: records each packet cycle by cycle and
// compares every bit period, handshake and status pulse with hand-derived values.
module tb_usb_tx_line_encoder;

    logic       clk;
    logic       rst;
    logic       start;
    logic       abort;
    logic [7:0] tx_byte;
    logic       byte_valid;
    logic       byte_last;
    logic       byte_ready;
    logic       busy;
    logic       done;
    logic       error;
    logic       dplus_out;
    logic       dminus_out;

    int checks   = 0;
    int failures = 0;

    localparam int NREC = 260;
    logic rec_dp   [0:NREC-1];
    logic rec_dm   [0:NREC-1];
    logic rec_rdy  [0:NREC-1];
    logic rec_done [0:NREC-1];
    logic rec_err  [0:NREC-1];
    logic rec_busy [0:NREC-1];
    logic [7:0] feed [0:3];

    usb_tx_line_encoder #(.CLKS_PER_BIT(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .tx_byte    (tx_byte),
        .byte_valid (byte_valid),
        .byte_last  (byte_last),
        .byte_ready (byte_ready),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .dplus_out  (dplus_out),
        .dminus_out (dminus_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle 0 is the cycle whose closing edge samples start.
    task automatic run_pkt(input int n_cyc, input int n_bytes, input int n_avail,
                           input int abort_cyc, input int rst_cyc, input int start2_cyc);
        int idx;
        idx = 0;
        @(negedge clk);
        for (int c = 0; c < n_cyc; c++) begin
            start      = (c == 0) || (c == start2_cyc);
            abort      = (c == abort_cyc);
            rst        = (c == rst_cyc);
            byte_valid = (idx < n_avail);
            tx_byte    = (idx < 4) ? feed[idx] : 8'h00;
            byte_last  = (idx == n_bytes - 1);
            #1;
            rec_dp[c]   = dplus_out;
            rec_dm[c]   = dminus_out;
            rec_rdy[c]  = byte_ready;
            rec_done[c] = done;
            rec_err[c]  = error;
            rec_busy[c] = busy;
            if (byte_ready && byte_valid) idx++;
            @(negedge clk);
        end
        start      = 1'b0;
        abort      = 1'b0;
        rst        = 1'b0;
        byte_valid = 1'b0;
        byte_last  = 1'b0;
    endtask

    function automatic logic [15:0] exp_period(input string s, input int b);
        byte ch;
        logic [1:0] v;
        ch = s[b];
        if (ch == "J")      v = 2'b10;
        else if (ch == "K") v = 2'b01;
        else                v = 2'b00;
        return {8{v}};
    endfunction

    function automatic logic [15:0] got_period(input int b);
        logic [15:0] w;
        w = '0;
        for (int i = 0; i < 8; i++) w[15-2*i -: 2] = {rec_dp[1+8*b+i], rec_dm[1+8*b+i]};
        return w;
    endfunction

    function automatic int count_rdy(input int n);
        int k;
        k = 0;
        for (int i = 0; i < n; i++) if (rec_rdy[i] === 1'b1) k++;
        return k;
    endfunction

    function automatic int count_done(input int n);
        int k;
        k = 0;
        for (int i = 0; i < n; i++) if (rec_done[i] === 1'b1) k++;
        return k;
    endfunction

    function automatic int count_err(input int n);
        int k;
        k = 0;
        for (int i = 0; i < n; i++) if (rec_err[i] === 1'b1) k++;
        return k;
    endfunction

    task automatic test_reset();
        abort = 1'b1;
        repeat (3) @(negedge clk);
        abort = 1'b0;
        checks++;
        if ({dplus_out, dminus_out, byte_ready, busy, done, error} !== 6'b100000) begin
            failures++;
            $display("FAIL reset_state got=%b exp=100000", {dplus_out, dminus_out, byte_ready, busy, done, error});
        end
        $display("reset: dp=%b dm=%b busy=%b", dplus_out, dminus_out, busy);
    endtask

    task automatic test_single_a5();
        string ex;
        ex = "KJKJKJKKKJJKJJKK00J";
        feed[0] = 8'hA5;
        run_pkt(160, 1, 1, -1, -1, -1);
        for (int b = 0; b < ex.len(); b++) begin
            checks++;
            if (got_period(b) !== exp_period(ex, b)) begin
                failures++;
                $display("FAIL a5_line period=%0d got=%h exp=%h", b, got_period(b), exp_period(ex, b));
            end
        end
        checks++;
        if (rec_rdy[64] !== 1'b1 || count_rdy(160) != 1) begin
            failures++;
            $display("FAIL a5_ready at64=%b count=%0d exp at64=1 count=1", rec_rdy[64], count_rdy(160));
        end
        checks++;
        if (rec_done[153] !== 1'b1 || count_done(160) != 1 || count_err(160) != 0) begin
            failures++;
            $display("FAIL a5_done at153=%b dones=%0d errs=%0d exp 1/1/0", rec_done[153], count_done(160), count_err(160));
        end
        $display("single 0xA5: ready=%0d done=%0d error=%0d", count_rdy(160), count_done(160), count_err(160));
    endtask

    task automatic test_stuff_ff();
        string ex;
        ex = "KJKJKJKKKKKKKJJJJ00J";
        feed[0] = 8'hFF;
        run_pkt(170, 1, 1, -1, -1, -1);
        for (int b = 0; b < ex.len(); b++) begin
            checks++;
            if (got_period(b) !== exp_period(ex, b)) begin
                failures++;
                $display("FAIL ff_line period=%0d got=%h exp=%h", b, got_period(b), exp_period(ex, b));
            end
        end
        checks++;
        if (rec_done[161] !== 1'b1 || count_done(170) != 1 || count_err(170) != 0) begin
            failures++;
            $display("FAIL ff_done at161=%b dones=%0d errs=%0d exp 1/1/0", rec_done[161], count_done(170), count_err(170));
        end
        $display("single 0xFF: done=%0d ready=%0d", count_done(170), count_rdy(170));
    endtask

    task automatic test_back_to_back();
        string ex;
        ex = "KJKJKJKKKKKKKJJJJJJJKKKKKK00J";
        feed[0] = 8'hFF;
        feed[1] = 8'hFF;
        run_pkt(240, 2, 2, -1, -1, -1);
        for (int b = 0; b < ex.len(); b++) begin
            checks++;
            if (got_period(b) !== exp_period(ex, b)) begin
                failures++;
                $display("FAIL ffff_line period=%0d got=%h exp=%h", b, got_period(b), exp_period(ex, b));
            end
        end
        checks++;
        if (rec_rdy[64] !== 1'b1 || rec_rdy[136] !== 1'b1 || count_rdy(240) != 2) begin
            failures++;
            $display("FAIL ffff_ready at64=%b at136=%b count=%0d exp 1/1/2", rec_rdy[64], rec_rdy[136], count_rdy(240));
        end
        checks++;
        if (rec_done[233] !== 1'b1 || {rec_dp[239], rec_dm[239]} !== 2'b10) begin
            failures++;
            $display("FAIL ffff_end done233=%b line=%b%b exp done=1 line=10", rec_done[233], rec_dp[239], rec_dm[239]);
        end
        $display("two 0xFF: ready=%0d done=%0d", count_rdy(240), count_done(240));
    endtask

    task automatic test_underrun();
        string ex;
        ex = "KJKJKJKKKJJKJJKK00J";
        feed[0] = 8'hA5;
        feed[1] = 8'h3C;
        run_pkt(160, 2, 1, -1, -1, -1);
        for (int b = 0; b < ex.len(); b++) begin
            checks++;
            if (got_period(b) !== exp_period(ex, b)) begin
                failures++;
                $display("FAIL underrun_line period=%0d got=%h exp=%h", b, got_period(b), exp_period(ex, b));
            end
        end
        checks++;
        if (rec_err[129] !== 1'b1 || count_err(160) != 1) begin
            failures++;
            $display("FAIL underrun_error at129=%b count=%0d exp 1/1", rec_err[129], count_err(160));
        end
        checks++;
        if (rec_rdy[64] !== 1'b1 || count_rdy(160) != 1 || rec_done[153] !== 1'b1) begin
            failures++;
            $display("FAIL underrun_hs ready64=%b readys=%0d done153=%b exp 1/1/1", rec_rdy[64], count_rdy(160), rec_done[153]);
        end
        $display("underrun: error=%0d ready=%0d done=%0d", count_err(160), count_rdy(160), count_done(160));
    endtask

    task automatic test_abort();
        string ex;
        ex = "KJKJKJKKKJJK00J";
        feed[0] = 8'hA5;
        feed[1] = 8'h12;
        feed[2] = 8'h34;
        run_pkt(140, 3, 3, 90, -1, -1);
        for (int b = 0; b < ex.len(); b++) begin
            checks++;
            if (got_period(b) !== exp_period(ex, b)) begin
                failures++;
                $display("FAIL abort_line period=%0d got=%h exp=%h", b, got_period(b), exp_period(ex, b));
            end
        end
        checks++;
        if (rec_done[121] !== 1'b1 || count_err(140) != 0 || count_rdy(140) != 1) begin
            failures++;
            $display("FAIL abort_status done121=%b errs=%0d readys=%0d exp 1/0/1", rec_done[121], count_err(140), count_rdy(140));
        end
        $display("abort: done=%0d error=%0d ready=%0d", count_done(140), count_err(140), count_rdy(140));
    endtask

    task automatic test_reset_mid();
        int bad;
        feed[0] = 8'hA5;
        feed[1] = 8'h5A;
        run_pkt(200, 2, 2, -1, 80, -1);
        checks++;
        if ({rec_dp[81], rec_dm[81], rec_busy[81], rec_done[81]} !== 4'b1000) begin
            failures++;
            $display("FAIL rstmid_next got=%b exp=1000", {rec_dp[81], rec_dm[81], rec_busy[81], rec_done[81]});
        end
        bad = 0;
        for (int c = 81; c < 200; c++) if ({rec_dp[c], rec_dm[c], rec_busy[c]} !== 3'b100) bad++;
        checks++;
        if (bad != 0 || count_done(200) != 0) begin
            failures++;
            $display("FAIL rstmid_quiet bad_cycles=%0d dones=%0d exp 0/0", bad, count_done(200));
        end
        $display("reset mid-packet: bad_cycles=%0d done=%0d", bad, count_done(200));
    endtask

    task automatic test_start_busy();
        string ex;
        ex = "KJKJKJKKKJJKJJKK00J";
        feed[0] = 8'hA5;
        run_pkt(175, 1, 1, -1, -1, 20);
        for (int b = 0; b < ex.len(); b++) begin
            checks++;
            if (got_period(b) !== exp_period(ex, b)) begin
                failures++;
                $display("FAIL startbusy_line period=%0d got=%h exp=%h", b, got_period(b), exp_period(ex, b));
            end
        end
        checks++;
        if (count_done(175) != 1 || rec_busy[170] !== 1'b0 || {rec_dp[170], rec_dm[170]} !== 2'b10) begin
            failures++;
            $display("FAIL startbusy_end dones=%0d busy170=%b line=%b%b exp 1/0/10", count_done(175), rec_busy[170], rec_dp[170], rec_dm[170]);
        end
        $display("start while busy: done=%0d busy_after=%b", count_done(175), rec_busy[170]);
    endtask

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        abort      = 1'b0;
        tx_byte    = 8'h00;
        byte_valid = 1'b0;
        byte_last  = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        test_reset();
        test_single_a5();
        test_stuff_ff();
        test_back_to_back();
        test_underrun();
        test_abort();
        test_reset_mid();
        test_start_busy();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
